// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiply/divide unit.
interface mdu_seq_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [XLEN-1:0]       a_i;
    logic [XLEN-1:0]       b_i;
    logic [REG_ADDR_W-1:0] reg_waddr_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  ready_o;
    logic [XLEN-1:0]       result_o;
    logic [REG_ADDR_W-1:0] reg_waddr_o;

    modport master (
        output start_i, op_i, a_i, b_i, reg_waddr_i, flush_i,
        input  busy_o, ready_o, result_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, reg_waddr_i, flush_i,
        output busy_o, ready_o, result_o, reg_waddr_o
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with the sign fixed up in a final cycle.
module mdu_seq #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    mdu_seq_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [XLEN-1:0]   ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2 = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [2:0]            op_q;
    logic                  neg_q;
    logic                  spec_q;
    logic [XLEN-1:0]       ma_q;
    logic [XLEN-1:0]       mb_q;
    logic [2*XLEN-1:0]     acc;
    logic [REG_ADDR_W-1:0] tag_q;
    logic                  ready_q;
    logic [XLEN-1:0]       result_q;
    logic [REG_ADDR_W-1:0] waddr_q;

    // launch-time decode
    logic            a_signed, b_signed, sa_in, sb_in, div_zero, div_ovf, neg_in;
    logic [XLEN-1:0] ma_in, mb_in, spec_val;

    always_comb begin
        a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                   (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
        b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
        sa_in    = a_signed & bus.a_i[XLEN-1];
        sb_in    = b_signed & bus.b_i[XLEN-1];
        ma_in    = sa_in ? (~bus.a_i + ONE) : bus.a_i;
        mb_in    = sb_in ? (~bus.b_i + ONE) : bus.b_i;
        div_zero = bus.op_i[2] && (bus.b_i == '0);
        div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.a_i == MINV) && (bus.b_i == '1);
        // remainder follows the dividend; product and quotient follow sa^sb
        neg_in   = (bus.op_i[2] && bus.op_i[1]) ? sa_in : (sa_in ^ sb_in);
        if (div_zero)
            spec_val = bus.op_i[1] ? bus.a_i : '1;
        else
            spec_val = bus.op_i[1] ? '0 : bus.a_i;
    end

    // one iteration of each datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_top;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // acc = {partial remainder, dividend bits still to shift in / quotient bits}
        div_top  = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_top >= {1'b0, mb_q};
        div_diff = div_top[XLEN-1:0] - mb_q;
        div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end

    // final sign correction and word select
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_word;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s   = neg_q ? (~acc + ONE2) : acc;
        div_word = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (spec_q)
            fix_res = acc[XLEN-1:0];
        else if (!op_q[2])
            fix_res = (op_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else
            fix_res = neg_q ? (~div_word + ONE) : div_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc      <= '0;
            tag_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q  <= bus.op_i;
                        tag_q <= bus.reg_waddr_i;
                        neg_q <= neg_in;
                        ma_q  <= ma_in;
                        mb_q  <= mb_in;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            spec_q <= 1'b1;
                            acc    <= {{XLEN{1'b0}}, spec_val};
                            state  <= FIX;
                        end else begin
                            spec_q <= 1'b0;
                            acc    <= {{XLEN{1'b0}}, bus.op_i[2] ? ma_in : mb_in};
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= op_q[2] ? div_next : mul_next;
                        if (cnt == CW'(XLEN-1))
                            state <= FIX;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.flush_i) begin
                        result_q <= fix_res;
                        waddr_q  <= tag_q;
                        ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = (state != IDLE);
    assign bus.ready_o     = ready_q;
    assign bus.result_o    = result_q;
    assign bus.reg_waddr_o = waddr_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq at XLEN=32 and XLEN=16 with hand-computed results.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int errs = 0;

    mdu_seq_if #(.XLEN(32), .REG_ADDR_W(5)) b32 ();
    mdu_seq_if #(.XLEN(16), .REG_ADDR_W(5)) b16 ();

    mdu_seq #(.XLEN(32), .REG_ADDR_W(5)) u32 (.clk(clk), .rst(rst), .bus(b32));
    mdu_seq #(.XLEN(16), .REG_ADDR_W(5)) u16 (.clk(clk), .rst(rst), .bus(b16));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
        if (w) begin
            b16.start_i = 1'b1; b16.op_i = op; b16.a_i = a[15:0]; b16.b_i = b[15:0];
            b16.reg_waddr_i = tag;
        end else begin
            b32.start_i = 1'b1; b32.op_i = op; b32.a_i = a; b32.b_i = b;
            b32.reg_waddr_i = tag;
        end
        step();
        b16.start_i = 1'b0;
        b32.start_i = 1'b0;
    endtask

    // n counts edges since the accepting edge; ready at n means n+1 cycles of latency
    task automatic wait_rdy(input bit w, input string nm, input int n0, input int exp_n,
                            input logic [31:0] exp_res, input logic [4:0] exp_tag);
        int n;
        int bc;
        n = n0;
        bc = 0;
        while (!(w ? b16.ready_o : b32.ready_o) && n < 200) begin
            if (w ? b16.busy_o : b32.busy_o) bc++;
            step();
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(exp_n));
        chk({nm, "_res"}, w ? {16'h0, b16.result_o} : b32.result_o, exp_res);
        chk({nm, "_tag"}, {27'h0, w ? b16.reg_waddr_o : b32.reg_waddr_o}, {27'h0, exp_tag});
        chk({nm, "_busy_at_rdy"}, {31'h0, w ? b16.busy_o : b32.busy_o}, 32'h0);
        chk({nm, "_busy_span"}, 32'(bc), 32'(n - n0));
    endtask

    task automatic no_rdy(input bit w, input string nm, input int cyc);
        int hits;
        hits = 0;
        repeat (cyc) begin
            if (w ? b16.ready_o : b32.ready_o) hits++;
            step();
        end
        chk(nm, 32'(hits), 32'h0);
    endtask

    task automatic op_chk(input bit w, input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          input int exp_n, input logic [31:0] exp_res);
        launch(w, op, a, b, tag);
        wait_rdy(w, nm, 0, exp_n, exp_res, tag);
    endtask

    initial begin
        b32.start_i = 0; b32.op_i = 0; b32.a_i = 0; b32.b_i = 0; b32.reg_waddr_i = 0; b32.flush_i = 0;
        b16.start_i = 0; b16.op_i = 0; b16.a_i = 0; b16.b_i = 0; b16.reg_waddr_i = 0; b16.flush_i = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", {31'h0, b32.busy_o}, 32'h0);
        chk("rst_ready", {31'h0, b32.ready_o}, 32'h0);
        chk("rst_result", b32.result_o, 32'h0);
        chk("rst_waddr", {27'h0, b32.reg_waddr_o}, 32'h0);
        chk("rst_result16", {16'h0, b16.result_o}, 32'h0);

        // MUL with signed-looking operand, low word; one-cycle ready pulse
        op_chk(0, "mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 33, 32'hFFFFFFEB);
        step();
        chk("mul_pulse", {31'h0, b32.ready_o}, 32'h0);
        chk("mul_hold", b32.result_o, 32'hFFFFFFEB);

        op_chk(0, "mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd1, 33, 32'h40000000);
        op_chk(0, "mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 33, 32'hFFFFFFFE);
        op_chk(0, "mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd3, 33, 32'hFFFFFFFF);
        op_chk(0, "div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd6, 33, 32'hFFFFFFFD);
        op_chk(0, "rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd7, 33, 32'hFFFFFFFF);
        op_chk(0, "divu",   3'b101, 32'd100,      32'd7,        5'd8, 33, 32'd14);
        op_chk(0, "remu",   3'b111, 32'd100,      32'd7,        5'd9, 33, 32'd2);

        // special cases bypass the iteration
        op_chk(0, "div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1, 32'h80000000);
        op_chk(0, "rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1, 32'h0);
        op_chk(0, "divu_dz",  3'b101, 32'h1234,     32'h0,        5'd12, 1, 32'hFFFFFFFF);
        op_chk(0, "remu_dz",  3'b111, 32'h1234,     32'h0,        5'd4,  1, 32'h1234);

        // flush at cycle 10 of a MUL: no ready, outputs keep the previous result
        launch(0, 3'b000, 32'd7, 32'd3, 5'd11);
        repeat (8) step();
        b32.flush_i = 1'b1;
        step();
        b32.flush_i = 1'b0;
        chk("flush_busy", {31'h0, b32.busy_o}, 32'h0);
        no_rdy(0, "flush_no_rdy", 40);
        chk("flush_result", b32.result_o, 32'h1234);
        chk("flush_waddr", {27'h0, b32.reg_waddr_o}, 32'd4);

        // DIVU 9/3 with a stray start while busy
        launch(0, 3'b101, 32'd9, 32'd3, 5'd12);
        repeat (4) step();
        b32.start_i = 1'b1; b32.op_i = 3'b000; b32.a_i = 32'd2; b32.b_i = 32'd2;
        b32.reg_waddr_i = 5'd9;
        step();
        b32.start_i = 1'b0;
        wait_rdy(0, "divu9", 5, 33, 32'd3, 5'd12);

        // back-to-back: start in the ready cycle, old result visible meanwhile
        launch(0, 3'b000, 32'd3, 32'd5, 5'd7);
        chk("b2b_old_res", b32.result_o, 32'd3);
        chk("b2b_busy", {31'h0, b32.busy_o}, 32'h1);
        wait_rdy(0, "b2b", 0, 33, 32'd15, 5'd7);

        // flush and start together in IDLE: start dropped
        b32.flush_i = 1'b1;
        launch(0, 3'b000, 32'd2, 32'd2, 5'd3);
        b32.flush_i = 1'b0;
        chk("flush_start_busy", {31'h0, b32.busy_o}, 32'h0);
        no_rdy(0, "flush_start_no_rdy", 40);

        // reset in the middle of an op
        launch(0, 3'b000, 32'd6, 32'd6, 5'd13);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", {31'h0, b32.busy_o}, 32'h0);
        chk("mid_rst_result", b32.result_o, 32'h0);
        chk("mid_rst_waddr", {27'h0, b32.reg_waddr_o}, 32'h0);
        rst = 1'b0;
        no_rdy(0, "mid_rst_no_rdy", 40);

        // XLEN=16 instance
        op_chk(1, "mul16",    3'b000, 32'd7,    32'hFFFD, 5'd5, 17, 32'hFFEB);
        op_chk(1, "mulh16",   3'b001, 32'h8000, 32'h8000, 5'd1, 17, 32'h4000);
        op_chk(1, "div16",    3'b100, 32'hFFF9, 32'd2,    5'd6, 17, 32'hFFFD);
        op_chk(1, "rem16",    3'b110, 32'hFFF9, 32'd2,    5'd7, 17, 32'hFFFF);
        op_chk(1, "divu16",   3'b101, 32'd100,  32'd7,    5'd8, 17, 32'd14);
        op_chk(1, "divu_dz16", 3'b101, 32'h1234, 32'h0,   5'd2, 1,  32'hFFFF);
        op_chk(1, "div_ovf16", 3'b100, 32'h8000, 32'hFFFF, 5'd3, 1, 32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
        $finish;
    end
endmodule
